// File: rtl/jpeg_zz_quantizer.sv
// Quantizer stage after the zigzag reorder: multiplies each coefficient by a
// programmable reciprocal, rounds half toward +inf and saturates to QW bits.
module jpeg_zz_quantizer #(
    parameter int DW = 12,
    parameter int QW = 11,
    parameter int RW = 17,
    parameter int SH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          dstrb,
    input  logic [DW-1:0] din,
    input  logic          qnt_wr,
    input  logic [5:0]    qnt_addr,
    input  logic [RW-1:0] qnt_val,
    output logic [QW-1:0] dout,
    output logic          douten,
    output logic          dsof,
    output logic          deob,
    output logic          busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int PW  = DW + RW + 1;
    localparam int RQW = PW - SH;

    localparam logic [RW-1:0]         UNITY = RW'(64'd1 << SH);
    localparam logic signed [PW-1:0]  RND   = PW'(64'd1 << (SH - 1));
    localparam logic signed [RQW-1:0] QMAX  = RQW'((1 << (QW - 1)) - 1);
    localparam logic signed [RQW-1:0] QMIN  = RQW'(-(1 << (QW - 1)));

    logic [0:0]    state;
    logic [5:0]    cnt;
    logic          accept;
    logic [5:0]    idx;
    logic [RW-1:0] tbl [64];

    logic          s1_valid;
    logic [DW-1:0] s1_din;
    logic [RW-1:0] s1_q;
    logic          s1_first;
    logic          s1_last;

    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  prod_rnd;
    logic signed [RQW-1:0] rq;
    logic [QW-1:0]         sat;

    // A start strobe always wins, so a block can be aborted from RUN.
    assign accept = ena & (dstrb | (state == ST_RUN));
    assign idx    = dstrb ? 6'd0 : cnt;
    assign busy   = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else if (accept) begin
            if (dstrb) begin
                state <= ST_RUN;
                cnt   <= 6'd1;
            end else if (cnt == 6'd63) begin
                state <= ST_IDLE;
                cnt   <= 6'd0;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Writes bypass ena; a same-edge S1 read sees the previous entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                tbl[i] <= UNITY;
            end
        end else if (qnt_wr) begin
            tbl[qnt_addr] <= qnt_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_q     <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (ena) begin
            s1_valid <= accept;
            if (accept) begin
                s1_din   <= din;
                s1_q     <= tbl[idx];
                s1_first <= (idx == 6'd0);
                s1_last  <= (idx == 6'd63);
            end
        end
    end

    always_comb begin
        prod     = PW'($signed(s1_din)) * PW'($signed({1'b0, s1_q}));
        prod_rnd = prod + RND;
        rq       = RQW'(prod_rnd >>> SH);
        if (rq > QMAX) begin
            sat = QMAX[QW-1:0];
        end else if (rq < QMIN) begin
            sat = QMIN[QW-1:0];
        end else begin
            sat = rq[QW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout   <= '0;
            douten <= 1'b0;
            dsof   <= 1'b0;
            deob   <= 1'b0;
        end else if (ena) begin
            douten <= s1_valid;
            dsof   <= s1_valid & s1_first;
            deob   <= s1_valid & s1_last;
            if (s1_valid) begin
                dout <= sat;
            end
        end
    end

endmodule

// File: doc/jpeg_zz_quantizer.md
Name: jpeg_zz_quantizer

Overview:
- Stage directly downstream of the zigzag reorder unit in the JPEG encoder datapath.
- Accepts one 8x8 block of DCT coefficients as a 64-sample serial stream in zigzag order.
- Quantizes each coefficient by multiplying it with a programmable reciprocal of the quantization table entry, then rounds and saturates.
- Emits the quantized stream with strobes for the run-length/Huffman stage.

Parameters:
DW, 12, input coefficient width (signed)
QW, 11, output coefficient width (signed, saturated)
RW, 17, reciprocal table entry width (unsigned); value = round(2^SH / q)
SH, 16, fixed-point shift applied after the multiply

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low
ena  input  1  clock enable; when low, all state (counter, pipeline, strobes) holds
dstrb  input  1  start-of-block; asserted with coefficient index 0
din  input  DW  signed coefficient, zigzag order
qnt_wr  input  1  reciprocal table write strobe (not gated by ena)
qnt_addr  input  6  table index (zigzag order)
qnt_val  input  RW  reciprocal value to write
dout  output  QW  quantized coefficient
douten  output  1  dout valid
dsof  output  1  high with the output for index 0
deob  output  1  high with the output for index 63
busy  output  1  a block is in progress at the input side

Behaviour:
- Reset (rst low, asynchronous):
  - dout=0, douten=0, dsof=0, deob=0, busy=0.
  - Coefficient counter cnt=0; state IDLE; pipeline valid bits cleared.
  - All 64 table entries = 2^SH (q=1, pass-through).
- State machine, advances only when ena=1:
  - IDLE: dstrb=1 -> accept din as index 0, cnt<=1, go to RUN.
  - RUN: each ena cycle accept din at index cnt and increment cnt. Accepting index 63 -> cnt<=0, return to IDLE.
  - dstrb=1 while in RUN aborts the current block: that sample is index 0 and cnt<=1. Samples already in the pipeline still drain.
  - In IDLE with dstrb=0, din is ignored and nothing is emitted.
- busy=1 in RUN.
- Pipeline, 2 ena-cycles of latency from sample acceptance to douten/dout:
  - S1: register din, tbl[index], first flag (index==0) and last flag (index==63).
  - S2: p = din * tbl (signed x unsigned; DW+RW+1 bits). r = (p + 2^(SH-1)) >>> SH, i.e. round half toward +inf. Saturate r to [-2^(QW-1), 2^(QW-1)-1], giving [-1024, 1023] at defaults. Register the result as dout.
  - douten, dsof, deob are registered alongside dout. dout holds its last value when douten=0.
- Table:
  - A qnt_wr=1 write lands at the clock edge, regardless of ena.
  - Same-cycle read of the same address in S1 returns the OLD value; the new value is used from the next read.
  - Writing during a block is legal; affected indices are quantized with whichever value is current at their S1.
- ena=0 freezes the counter, state, both pipeline stages and all strobes. Outputs hold; douten keeps its value.
- Reset mid-block: everything clears at once. The next block requires a new dstrb.
- Back-to-back blocks: dstrb can arrive in the cycle immediately after index 63, giving no gap in the output stream.

Test Plan:
- Reset then pass-through: dstrb with din=100, then 63 samples of din=-37 with ena=1 -> two cycles later dout=100 with dsof=1; then 63 outputs of -37; deob=1 on the 64th output; busy falls after index 63 is accepted.
- Quantization rounding:
  - tbl[0]=4096 (q=16), din=-100 at index 0 -> dout=-6.
  - tbl[1]=5958 (q~11), din=50 -> dout=5.
  - din=8 with tbl=4096 (0.5 exactly) -> dout=1.
- Saturation: pass-through table, din=2047 -> dout=1023; din=-2048 -> dout=-1024.
- ena stall: drop ena for 3 cycles at index 20 -> no counter advance, outputs frozen, douten held. Resume -> indices 21..63 follow in order, deob on index 63.
- Abort and back-to-back:
  - dstrb at index 30 -> new dsof appears 2 cycles later, and the earlier block never produces deob.
  - dstrb right after index 63 -> continuous douten across the block boundary.
- Async reset mid-block at index 40 -> all outputs 0 immediately, table back to 2^16. A following block passes through unchanged.
